// File: rtl/wishbone_target_classic.sv
// Wishbone classic-cycle register target: NUM_REGS registers, optional wait
// states, error termination for out-of-range addresses.
module wishbone_target_classic #(
  parameter int unsigned DAT_WIDTH   = 8,
  parameter int unsigned ADR_WIDTH   = 4,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          cyc_i,
  input  logic                          stb_i,
  input  logic                          we_i,
  input  logic [ADR_WIDTH-1:0]          adr_i,
  input  logic [DAT_WIDTH-1:0]          dat_i,
  output logic [DAT_WIDTH-1:0]          dat_o,
  output logic                          ack_o,
  output logic                          err_o,
  output logic [NUM_REGS*DAT_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]           wr_pulse_o
);

  localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                      r_state, w_state_nxt;
  logic [3:0]                  r_cnt, w_cnt_nxt;
  logic                        r_we;
  logic [ADR_WIDTH-1:0]        r_adr;
  logic [DAT_WIDTH-1:0]        r_dat;
  logic [NUM_REGS*DAT_WIDTH-1:0] r_regs;

  logic                        w_req;
  logic                        w_capture;
  logic                        w_enter_resp;
  logic                        w_we;
  logic [ADR_WIDTH-1:0]        w_adr;
  logic [DAT_WIDTH-1:0]        w_dat;
  logic [NUM_REGS-1:0]         w_sel;
  logic                        w_valid;
  logic [DAT_WIDTH-1:0]        w_rd;

  assign w_req  = cyc_i && stb_i;
  assign regs_o = r_regs;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_capture    = 1'b0;
    w_enter_resp = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_capture = 1'b1;
          if (WAIT_STATES == 0) begin
            w_state_nxt  = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt  = S_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // With no wait states RESP is entered on the capture edge, so use the live bus.
  assign w_we  = (r_state == S_IDLE) ? we_i  : r_we;
  assign w_adr = (r_state == S_IDLE) ? adr_i : r_adr;
  assign w_dat = (r_state == S_IDLE) ? dat_i : r_dat;

  always_comb begin
    w_sel = '0;
    w_rd  = '0;
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      if (w_adr == ADR_WIDTH'(k)) begin
        w_sel[k] = 1'b1;
        w_rd     = r_regs[k*DAT_WIDTH +: DAT_WIDTH];
      end
    end
  end

  assign w_valid = |w_sel;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we       <= 1'b0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_regs     <= '0;
      ack_o      <= 1'b0;
      err_o      <= 1'b0;
      dat_o      <= '0;
      wr_pulse_o <= '0;
    end else begin
      if (w_capture) begin
        r_we  <= we_i;
        r_adr <= adr_i;
        r_dat <= dat_i;
      end
      ack_o      <= w_enter_resp && w_valid;
      err_o      <= w_enter_resp && !w_valid;
      dat_o      <= (w_enter_resp && w_valid && !w_we) ? w_rd : '0;
      wr_pulse_o <= (w_enter_resp && w_we) ? w_sel : '0;
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        if (w_enter_resp && w_we && w_sel[k]) begin
          r_regs[k*DAT_WIDTH +: DAT_WIDTH] <= w_dat;
        end
      end
    end
  end

endmodule

// File: tb/tb_wishbone_target_classic.sv
// Randomized bench for wishbone_target_classic: three instances (0, 3, 5 wait
// states) checked against a register-array model with timing from the bus rules.
module tb_wishbone_target_classic;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cyc   [3];
  logic       stb   [3];
  logic       we    [3];
  logic [3:0] adr   [3];
  logic [7:0] dat_w [3];
  logic [7:0] dat_r [3];
  logic       ack   [3];
  logic       err   [3];
  logic [63:0] regs [3];
  logic [7:0] pulse [3];

  logic [7:0] mdl [3][8];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wishbone_target_classic #(
      .DAT_WIDTH  (8),
      .ADR_WIDTH  (4),
      .NUM_REGS   (8),
      .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 3 : 5)
    ) u_dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .cyc_i     (cyc[g]),
      .stb_i     (stb[g]),
      .we_i      (we[g]),
      .adr_i     (adr[g]),
      .dat_i     (dat_w[g]),
      .dat_o     (dat_r[g]),
      .ack_o     (ack[g]),
      .err_o     (err[g]),
      .regs_o    (regs[g]),
      .wr_pulse_o(pulse[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int ws_of(input int u);
    return (u == 0) ? 0 : (u == 1) ? 3 : 5;
  endfunction

  function automatic logic [63:0] packm(input int u);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = mdl[u][k];
    return r;
  endfunction

  task automatic chk_quiet(input string tag, input int u);
    chk({tag, "_ack"}, 64'(ack[u]), 64'd0);
    chk({tag, "_err"}, 64'(err[u]), 64'd0);
    chk({tag, "_dat"}, 64'(dat_r[u]), 64'd0);
    chk({tag, "_pulse"}, 64'(pulse[u]), 64'd0);
  endtask

  // One complete transaction; response expected WS cycles after the capture edge.
  task automatic txn(input int u, input logic w, input logic [3:0] a, input logic [7:0] d);
    logic       valid;
    logic [7:0] exp_dat;
    logic [7:0] oh;
    @(negedge clk);
    cyc[u] = 1'b1; stb[u] = 1'b1; we[u] = w; adr[u] = a; dat_w[u] = d;
    @(posedge clk);
    @(negedge clk);
    we[u] = 1'($urandom); adr[u] = 4'($urandom); dat_w[u] = 8'($urandom);
    for (int n = 0; n < ws_of(u); n++) begin
      chk("wait_ack", 64'(ack[u]), 64'd0);
      chk("wait_err", 64'(err[u]), 64'd0);
      @(negedge clk);
    end
    valid   = (a < 4'd8);
    exp_dat = (valid && !w) ? mdl[u][a[2:0]] : 8'd0;
    oh      = (valid && w) ? (8'd1 << a[2:0]) : 8'd0;
    if (valid && w) mdl[u][a[2:0]] = d;
    chk("resp_ack", 64'(ack[u]), 64'(valid));
    chk("resp_err", 64'(err[u]), 64'(!valid));
    chk("resp_dat", 64'(dat_r[u]), 64'(exp_dat));
    chk("resp_pulse", 64'(pulse[u]), 64'(oh));
    chk("resp_regs", regs[u], packm(u));
    cyc[u] = 1'b0; stb[u] = 1'b0;
    @(negedge clk);
    chk_quiet("post", u);
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      cyc[u] = 1'b0; stb[u] = 1'b0; we[u] = 1'b0; adr[u] = '0; dat_w[u] = '0;
      for (int k = 0; k < 8; k++) mdl[u][k] = 8'd0;
    end

    // Reset state, then a request on the first edge after release.
    #12;
    for (int u = 0; u < 3; u++) begin
      chk_quiet("rst", u);
      chk("rst_regs", regs[u], 64'd0);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    txn(0, 1'b1, 4'd3, 8'hA5);
    txn(0, 1'b0, 4'd3, 8'h00);

    // Out-of-range write, then wait-state read.
    txn(0, 1'b1, 4'd9, 8'hFF);
    txn(1, 1'b1, 4'd6, 8'h6C);
    txn(1, 1'b0, 4'd6, 8'h00);

    // Back-to-back reads with strobe held high.
    txn(0, 1'b1, 4'd0, 8'h11);
    txn(0, 1'b1, 4'd1, 8'h22);
    txn(0, 1'b1, 4'd2, 8'h33);
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_ack", 64'(ack[0]), 64'd1);
      chk("b2b_dat", 64'(dat_r[0]), 64'(mdl[0][i]));
      if (i < 2) adr[0] = 4'(i + 1);
      else begin cyc[0] = 1'b0; stb[0] = 1'b0; end
      @(negedge clk);
      chk("b2b_gap", 64'(ack[0]), 64'd0);
    end

    // Abort: cyc dropped two cycles into a 5-wait-state write.
    txn(2, 1'b1, 4'd1, 8'h3C);
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 4'd1; dat_w[2] = 8'h5A;
    repeat (2) @(negedge clk);
    cyc[2] = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk_quiet("abort", 2);
    end
    stb[2] = 1'b0;
    chk("abort_regs", regs[2], packm(2));
    txn(2, 1'b0, 4'd1, 8'h00);

    // Randomized traffic on every instance.
    for (int u = 0; u < 3; u++) begin
      for (int i = 0; i < 20; i++) begin
        txn(u, 1'($urandom), 4'($urandom), 8'($urandom));
      end
    end

    // Asynchronous reset while instance 1 sits in WAIT.
    for (int u = 0; u < 3; u++) mdl[u][7] = 8'hE7;
    for (int u = 0; u < 3; u++) txn(u, 1'b1, 4'd7, 8'hE7);
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 4'd2; dat_w[1] = 8'h77;
    @(posedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    for (int u = 0; u < 3; u++) begin
      for (int k = 0; k < 8; k++) mdl[u][k] = 8'd0;
      chk_quiet("arst", u);
      chk("arst_regs", regs[u], 64'd0);
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk_quiet("after_rst", 1);
      chk("after_rst_regs", regs[1], 64'd0);
    end
    txn(1, 1'b1, 4'd2, 8'h77);
    txn(1, 1'b0, 4'd2, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wishbone_target_classic.md
WISHBONE_TARGET_CLASSIC -- requirements
Module: wishbone_target_classic

Interface
REQ-001 The block SHALL have parameter DAT_WIDTH, default 8, meaning data bus width in bits.
REQ-002 The block SHALL have parameter ADR_WIDTH, default 4, meaning address bus width in bits.
REQ-003 The block SHALL have parameter NUM_REGS, default 8, meaning number of registers, legal range 1..2**ADR_WIDTH.
REQ-004 The block SHALL have parameter WAIT_STATES, default 0, meaning extra cycles inserted before the response, legal range 0..15.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port cyc_i, input, 1 bit: Wishbone bus cycle in progress.
REQ-008 The block SHALL have port stb_i, input, 1 bit: Wishbone strobe.
REQ-009 The block SHALL have port we_i, input, 1 bit: write enable, 1 = write, 0 = read.
REQ-010 The block SHALL have port adr_i, input, ADR_WIDTH bits: register index.
REQ-011 The block SHALL have port dat_i, input, DAT_WIDTH bits: write data.
REQ-012 The block SHALL have port dat_o, output, DAT_WIDTH bits: read data.
REQ-013 The block SHALL have port ack_o, output, 1 bit: normal termination.
REQ-014 The block SHALL have port err_o, output, 1 bit: error termination.
REQ-015 The block SHALL have port regs_o, output, NUM_REGS*DAT_WIDTH bits: register contents, register k at bits [k*DAT_WIDTH +: DAT_WIDTH].
REQ-016 The block SHALL have port wr_pulse_o, output, NUM_REGS bits: one-hot write-event strobe per register.

Function
REQ-017 The block SHALL implement a state machine with states IDLE, WAIT and RESP, and a 4-bit wait counter.
REQ-018 In IDLE, if cyc_i && stb_i is sampled high: with WAIT_STATES=0 the next state SHALL be RESP; otherwise the next state SHALL be WAIT with the counter loaded to WAIT_STATES-1.
REQ-019 At that IDLE-exit edge the block SHALL capture adr_i, we_i and dat_i into request registers; later changes on these inputs SHALL NOT affect the transaction.
REQ-020 In WAIT, if cyc_i or stb_i is low, the next state SHALL be IDLE (abort), with no response, no write and no pulse.
REQ-021 In WAIT, otherwise, the counter SHALL decrement each cycle, and the transition to RESP SHALL occur on the cycle the counter equals 0.
REQ-022 ack_o or err_o SHALL rise exactly 1+WAIT_STATES cycles after the first edge at which cyc_i && stb_i is sampled high.
REQ-023 RESP SHALL last exactly one cycle, and its next state SHALL always be IDLE; the strobe is not re-sampled in RESP, so the minimum transaction period is 2+WAIT_STATES cycles.
REQ-024 In RESP with captured address < NUM_REGS: ack_o SHALL be 1 and err_o 0.
REQ-025 In RESP with captured address >= NUM_REGS: err_o SHALL be 1, ack_o 0, no register SHALL change, wr_pulse_o SHALL be 0, and dat_o SHALL be 0.
REQ-026 A valid write SHALL update the register on the edge entering RESP, so regs_o reflects the new value in the same cycle ack_o is high.
REQ-027 For a valid write, wr_pulse_o[adr] SHALL be high for exactly the RESP cycle.
REQ-028 For a valid read, dat_o SHALL be registered and SHALL equal the register value at the edge entering RESP.
REQ-029 Outside RESP, dat_o SHALL be 0.
REQ-030 ack_o and err_o SHALL never be high simultaneously, and SHALL be high only in RESP.
REQ-031 If cyc_i drops during RESP, the response SHALL still complete for that cycle; the controller is responsible for ignoring it.

Reset
REQ-032 While rst_ni = 0, the following SHALL hold:
  - state IDLE;
  - counter 0;
  - all registers, request registers, dat_o, ack_o, err_o and wr_pulse_o 0.
REQ-033 Assertion of rst_ni mid-transaction SHALL abandon the transaction without a response or write.
REQ-034 The first request SHALL be accepted on the first rising edge at which rst_ni is 1.

Verification
REQ-035 Write then read (WAIT_STATES=0):
  - stimulus: write 0xA5 to adr 3, then read adr 3;
  - response: ack_o high in cycle 2 of each transaction, wr_pulse_o = 8'b0000_1000 with the write ack, then dat_o = 0xA5 with the read ack.
REQ-036 Wait states (WAIT_STATES=3):
  - stimulus: read with cyc/stb held high;
  - response: ack_o rises exactly 4 cycles after the request is sampled, and is high for one cycle.
REQ-037 Out-of-range access (NUM_REGS=8):
  - stimulus: write 0xFF to adr 9;
  - response: err_o high for 1 cycle, ack_o 0, regs_o unchanged, wr_pulse_o 0.
REQ-038 Back-to-back transactions:
  - stimulus: stb held high across 3 reads of adr 0,1,2 holding values 0x11, 0x22, 0x33;
  - response: acks spaced 2 cycles apart, dat_o = 0x11, 0x22, 0x33 in turn.
REQ-039 Abort (WAIT_STATES=5):
  - stimulus: write 0x5A to adr 1, with cyc_i dropped after 2 cycles;
  - response: no ack, no err, register 1 unchanged, state returns to IDLE.
REQ-040 Reset during WAIT:
  - stimulus: pull rst_ni low asynchronously mid-clock-period;
  - response: all outputs 0 immediately, no response after release, the next request completes normally.
